fetch_decode: RTL
=================

Name: fetch_decode

Overview:
- Front-end stage directly upstream of the reservation-station/register-file block.
- Fetches 32-bit RV32I instruction words from instruction memory over a req/ack handshake.
- Splits each word into opcode/rd/fun3/rs1/rs2/fun7/imm fields with the PC, and presents each instruction for exactly one clock.
- Honours the downstream busy signal and the next-PC redirect (npc/get_npc) returned by the consumer.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  32  fetch address (word aligned); stable while imem_req is high.
- imem_rdata  input  32  instruction word; valid when imem_ack is high.
- imem_ack  input  1  single-cycle completion pulse; latency is 1 or more cycles after the request.
- is_busy  input  1  downstream has no free station; do not issue.
- get_npc  input  1  redirect strobe.
- npc  input  32  redirect target PC.
- opcode  output  7  inst[6:0]; 7'h00 means no instruction this cycle.
- rd  output  5  inst[11:7].
- fun3  output  3  inst[14:12].
- rs1  output  5  inst[19:15].
- rs2  output  5  inst[24:20].
- fun7  output  7  see Behaviour.
- imm  output  32  sign-extended immediate per format.
- opc  output  32  PC of the issued instruction.

Behaviour:
- All outputs are registered.
- Reset, synchronous and active-high, overrides everything including a redirect in the same cycle:
  - pc = RESET_PC; state = FETCH.
  - imem_req = 0.
  - opcode, rd, fun3, rs1, rs2, fun7, imm = 0; opc = 0.
  - Internal instruction latch marked empty.
- States:
  - FETCH: drive imem_req = 1 with imem_addr = pc; go to WAIT next cycle.
  - WAIT: hold req and addr. On imem_ack: latch imem_rdata and the PC, drop req, go to ISSUE.
  - ISSUE: if !is_busy, register the decoded fields onto the outputs for one cycle, pc = pc + 4 (wrapping mod 2^32), go to FETCH. If is_busy, outputs carry opcode = 0, the latch is held, and the state stays ISSUE.
  - DRAIN: a fetch is in flight after a redirect. Keep req high until imem_ack, discard the returned word, then go to FETCH.
- Outputs in every cycle with no issue: opcode = 0. Other fields hold their last values; the consumer ignores them.
- Throughput: one instruction per 3 cycles at minimum with 1-cycle ack latency (FETCH, WAIT, ISSUE). Issue is the cycle after ack, provided not busy.
- Redirect, when get_npc = 1 and not in reset:
  - pc = npc; the latch is cleared; no issue in this cycle (opcode = 0).
  - From WAIT with no ack this cycle: go to DRAIN. With ack this cycle: discard the word and go to FETCH.
  - From FETCH or ISSUE: go to FETCH.
  - get_npc in DRAIN updates pc only.
- Immediate formats:
  - I-type: OP_IMM 0010011, LOAD 0000011, JALR 1100111. imm = sext(inst[31:20]).
  - S-type: 0100011. imm = sext({inst[31:25], inst[11:7]}).
  - B-type: 1100011. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type: LUI 0110111, AUIPC 0010111. imm = {inst[31:12], 12'h0}.
  - J-type: 1101111. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R-type and all others: imm = 0.
- fun7:
  - R-type (0110011): fun7 = inst[31:25].
  - OP_IMM with fun3 = 001 or 101 (shifts): fun7 = inst[31:25].
  - All other cases: fun7 = 0, so a negative ADDI is not seen downstream as SUB.
- Whole-zero word 32'h0: issued as opcode 0, i.e. a bubble; pc still advances.
- Ack arriving outside WAIT/DRAIN is ignored.

Optional Feature:
- Macro: FD_PREFETCH_EN.
- Defined:
  - Adds one prefetch slot; the next fetch (pc + 4) issues in the cycle the current word is latched.
  - While ISSUE is stalled by is_busy, the second word may complete into the slot; no further request is made while the slot is full.
  - Sustained rate is one instruction per cycle when ack latency is 1 and not busy.
  - A redirect flushes the slot and drains any in-flight fetch exactly as DRAIN does.
- Undefined: strictly one outstanding fetch; no slot; behaviour as above.

Test Plan:
- Reset: rst high for 2 cycles, RESET_PC = 0 -> after release, imem_req = 1 with addr 0; opcode = 0 throughout reset.
- Word 0x00500093 at addr 0, ack latency 1 -> one cycle with opcode 0010011, rd 1, rs1 0, fun3 0, imm 5, fun7 0, opc 0. Next request addr 4.
- Word 0xFFF00093 then 0x4030D113:
  - First: imm 0xFFFFFFFF, fun7 0.
  - Second: opcode 0010011, rd 2, rs1 1, fun3 101, fun7 0100000, imm 0x00000403.
- Word 0x0020A423 (sw x2,8(x1)) -> opcode 0100011, rs1 1, rs2 2, fun3 010, imm 8, fun7 0.
- Busy: is_busy high 3 cycles while in ISSUE -> opcode 0 for those 3 cycles, then exactly one issue cycle; pc advances by 4 only once.
- Redirect: get_npc = 1, npc = 0x100 while in WAIT, stale ack arriving 2 cycles later -> stale word never issued; next imem_addr = 0x100; next issued opc = 0x100.

Source files
------------

// File: rtl/fetch_decode.sv
// ============================================================================
//  Module   : fetch_decode
//  Purpose  : RV32I front end. Fetches instruction words over a req/ack
//             handshake, splits them into decoded fields plus PC, and presents
//             each instruction on the registered outputs for exactly one clock.
//             Honours downstream back-pressure (is_busy) and next-PC redirects
//             (get_npc/npc).
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             imem_req/addr/rdata/ack   - instruction memory handshake
//             is_busy                   - downstream cannot accept an issue
//             get_npc, npc              - redirect strobe and target PC
//             opcode..imm, opc          - decoded instruction (opcode 0 = none)
//  Options  : `define FD_PREFETCH_EN adds a one-word prefetch slot so that a
//             fetch can be in flight while the previous word waits to issue.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  input  logic            is_busy,
  input  logic            get_npc,
  input  logic [XLEN-1:0] npc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      fun3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      fun7,
  output logic [31:0]     imm,
  output logic [XLEN-1:0] opc
);

  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_reg    = 7'b0110011;

  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  // Fetch-side registers shared by both build variants
  logic            req_q,  req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_q,   pc_d;

  // Word and PC presented to the decoder, and the one-cycle issue strobe
  logic [31:0]     w_dec_word;
  logic [XLEN-1:0] w_dec_pc;
  logic            w_issue;

  // Registered outputs
  logic [6:0]      opcode_q, opcode_d;
  logic [4:0]      rd_q,     rd_d;
  logic [2:0]      fun3_q,   fun3_d;
  logic [4:0]      rs1_q,    rs1_d;
  logic [4:0]      rs2_q,    rs2_d;
  logic [6:0]      fun7_q,   fun7_d;
  logic [31:0]     imm_q,    imm_d;
  logic [XLEN-1:0] opc_q,    opc_d;

`ifdef FD_PREFETCH_EN
  // --------------------------------------------------------------------------
  // Prefetch variant: a two-entry word buffer (current + slot) fed by a fetch
  // engine that keeps one request in flight whenever a buffer entry is free.
  // pc_q is the address of the next word to request.
  // --------------------------------------------------------------------------
  logic [31:0]     bw_q [2];
  logic [31:0]     bw_d [2];
  logic [XLEN-1:0] bp_q [2];
  logic [XLEN-1:0] bp_d [2];
  logic [1:0]      cnt_q, cnt_d;
  logic            drain_q, drain_d;
  logic            w_ack;
  logic [1:0]      w_mid;

  assign w_ack      = req_q & imem_ack;
  assign w_issue    = (cnt_q != 2'd0) & ~is_busy & ~get_npc;
  assign w_mid      = cnt_q - {1'b0, w_issue};
  assign w_dec_word = bw_q[0];
  assign w_dec_pc   = bp_q[0];

  always_comb begin
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    bp_d    = bp_q;
    drain_d = drain_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    if (get_npc) begin
      cnt_d = 2'd0;
      pc_d  = npc;
      if (req_q && !imem_ack) begin
        // The in-flight word must still complete; throw it away when it does
        drain_d = 1'b1;
      end else begin
        drain_d = 1'b0;
        req_d   = 1'b1;
        addr_d  = npc;
        pc_d    = npc + c_pc_step;
      end
    end else begin
      if (w_issue) begin
        bw_d[0] = bw_q[1];
        bp_d[0] = bp_q[1];
      end
      // At most one request is outstanding and it was only made with a free
      // entry, so w_mid is 0 or 1 whenever a word lands here.
      if (w_ack && !drain_q) begin
        bw_d[w_mid[0]] = imem_rdata;
        bp_d[w_mid[0]] = addr_q;
      end
      cnt_d = w_mid + {1'b0, w_ack & ~drain_q};
      if (w_ack) begin
        drain_d = 1'b0;
      end
      if (!req_q || w_ack) begin
        if (cnt_d <= 2'd1) begin
          req_d  = 1'b1;
          addr_d = pc_q;
          pc_d   = pc_q + c_pc_step;
        end else begin
          req_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      drain_q <= 1'b0;
      bw_q[0] <= '0;
      bw_q[1] <= '0;
      bp_q[0] <= '0;
      bp_q[1] <= '0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      bw_q    <= bw_d;
      bp_q    <= bp_d;
    end
  end

`else
  // --------------------------------------------------------------------------
  // Single-outstanding variant: FETCH -> WAIT -> ISSUE, with DRAIN absorbing a
  // fetch that was already in flight when a redirect arrived.
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_issue = 2'd2;
  localparam logic [1:0] c_st_drain = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_vld_q, inst_vld_d;

  assign w_issue    = (state_q == c_st_issue) & inst_vld_q & ~is_busy & ~get_npc;
  assign w_dec_word = inst_q;
  assign w_dec_pc   = inst_pc_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_st_fetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. imem_req is registered, so the first FETCH cycle after
  // reset has req low; FETCH only advances once the request is visible. A
  // redirect while that request is visible must drain it, otherwise its ack
  // would later be mistaken for the redirected fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_fetch: begin
        if (get_npc)    state_d = req_q ? c_st_drain : c_st_fetch;
        else if (req_q) state_d = c_st_wait;
      end
      c_st_wait: begin
        if (get_npc)       state_d = imem_ack ? c_st_fetch : c_st_drain;
        else if (imem_ack) state_d = c_st_issue;
      end
      c_st_issue: begin
        if (get_npc || !is_busy) state_d = c_st_fetch;
      end
      default: begin
        if (imem_ack) state_d = c_st_fetch;
      end
    endcase
  end

  // Fetch datapath and instruction latch
  always_comb begin
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = (state_d != c_st_issue);
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_vld_d = inst_vld_q;
    if (get_npc) begin
      pc_d       = npc;
      inst_vld_d = 1'b0;
    end else begin
      if ((state_q == c_st_wait) && imem_ack) begin
        inst_d     = imem_rdata;
        inst_pc_d  = pc_q;
        inst_vld_d = 1'b1;
      end
      if (w_issue) begin
        pc_d       = pc_q + c_pc_step;
        inst_vld_d = 1'b0;
      end
    end
    // A new request address is only taken on entry to FETCH; it then stays
    // stable until the matching ack.
    if (state_d == c_st_fetch) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_vld_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_vld_q <= inst_vld_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Field decode of the word waiting to issue
  // --------------------------------------------------------------------------
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [31:0] w_imm;
  logic [6:0]  w_f7;

  assign w_op = w_dec_word[6:0];
  assign w_f3 = w_dec_word[14:12];

  always_comb begin
    w_imm = 32'h0;
    case (w_op)
      c_op_imm, c_op_load, c_op_jalr:
        w_imm = {{20{w_dec_word[31]}}, w_dec_word[31:20]};
      c_op_store:
        w_imm = {{20{w_dec_word[31]}}, w_dec_word[31:25], w_dec_word[11:7]};
      c_op_branch:
        w_imm = {{19{w_dec_word[31]}}, w_dec_word[31], w_dec_word[7],
                 w_dec_word[30:25], w_dec_word[11:8], 1'b0};
      c_op_lui, c_op_auipc:
        w_imm = {w_dec_word[31:12], 12'h0};
      c_op_jal:
        w_imm = {{11{w_dec_word[31]}}, w_dec_word[31], w_dec_word[19:12],
                 w_dec_word[20], w_dec_word[30:21], 1'b0};
      default:
        w_imm = 32'h0;
    endcase
  end

  // fun7 is only meaningful for R-type and immediate shifts; zero it elsewhere
  // so an I-type immediate with bit 30 set never looks like SUB/SRA.
  always_comb begin
    w_f7 = 7'h0;
    if ((w_op == c_op_reg) ||
        ((w_op == c_op_imm) && ((w_f3 == 3'b001) || (w_f3 == 3'b101)))) begin
      w_f7 = w_dec_word[31:25];
    end
  end

  // Output logic: opcode returns to zero in every non-issue cycle, the other
  // fields keep their last values.
  always_comb begin
    opcode_d = 7'h0;
    rd_d     = rd_q;
    fun3_d   = fun3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    fun7_d   = fun7_q;
    imm_d    = imm_q;
    opc_d    = opc_q;
    if (w_issue) begin
      opcode_d = w_op;
      rd_d     = w_dec_word[11:7];
      fun3_d   = w_f3;
      rs1_d    = w_dec_word[19:15];
      rs2_d    = w_dec_word[24:20];
      fun7_d   = w_f7;
      imm_d    = w_imm;
      opc_d    = w_dec_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= 7'h0;
      rd_q     <= 5'h0;
      fun3_q   <= 3'h0;
      rs1_q    <= 5'h0;
      rs2_q    <= 5'h0;
      fun7_q   <= 7'h0;
      imm_q    <= 32'h0;
      opc_q    <= '0;
    end else begin
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      fun3_q   <= fun3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      fun7_q   <= fun7_d;
      imm_q    <= imm_d;
      opc_q    <= opc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign opcode    = opcode_q;
  assign rd        = rd_q;
  assign fun3      = fun3_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign fun7      = fun7_q;
  assign imm       = imm_q;
  assign opc       = opc_q;

endmodule

`default_nettype wire
